// File: rtl/debug_sequencer.sv
// debug_sequencer: executes debugPort commands against CPU run control, memory and register bank.
// Every wait state is bounded by TIMEOUT; the outcome is reported through DEBUG_ERR at ACK time.
module debug_sequencer #(
    parameter int TIMEOUT = 255
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       DEBUG_REQX,
    input  logic [2:0] DEBUG_OPX,
    input  logic [3:0] DEBUG_ARGX,
    output logic       DEBUG_ACKX,
    output logic       DEBUG_ADDR_LDX,
    output logic       DEBUG_ADDR_INCX,
    output logic       DEBUG_DOUT_LDX,
    output logic [1:0] DEBUG_DATAX,
    output logic       DEBUG_ERR,
    output logic       CPU_HALT_REQ,
    input  logic       CPU_HALTED,
    output logic       CPU_STEP,
    output logic       DEBUG_MEM_RD,
    output logic       DEBUG_MEM_WR,
    input  logic       MEM_RDY,
    output logic [3:0] DEBUG_REGB_ADDR,
    output logic       DEBUG_REG_WR
);
    localparam logic [2:0] OP_NONE = 3'd0, OP_STOP = 3'd1, OP_RUN = 3'd2, OP_STEP = 3'd3,
                           OP_RD_MEM = 3'd4, OP_WR_MEM = 3'd5, OP_RD_REG = 3'd6, OP_WR_REG = 3'd7;
    localparam logic [1:0] DATAX_DIN = 2'd0, DATAX_REGB_DATA = 2'd1, DATAX_PC_A_NEXT = 2'd2,
                           DATAX_CC_DATA = 2'd3;
    localparam logic [3:0] IDLE = 4'd0, DECODE = 4'd1, HALT_WAIT = 4'd2, STEP_LOW = 4'd3,
                           STEP_HIGH = 4'd4, MEM_WAIT = 4'd5, REG_RD = 4'd6, DONE = 4'd7,
                           REQ_CLR = 4'd8;

    logic [3:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] op_q, op_d;
    logic [3:0] arg_q, arg_d;
    logic       err_q, err_d;
    logic       halt_q, halt_d;
    logic       timeout, halted_ok, is_mem, is_rd, is_reg, reg_on;

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= OP_NONE;
            arg_q   <= '0;
            err_q   <= 1'b0;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            arg_q   <= arg_d;
            err_q   <= err_d;
            halt_q  <= halt_d;
        end
    end

    // timeout fires on the last permitted waiting cycle, so a wait lasts exactly TIMEOUT cycles
    assign timeout = cnt_q == 8'(TIMEOUT - 1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        arg_d   = arg_q;
        err_d   = err_q;
        halt_d  = halt_q;
        case (state_q)
            IDLE: if (DEBUG_REQX) begin
                state_d = DECODE;
                op_d    = DEBUG_OPX;
                arg_d   = DEBUG_ARGX;
            end
            DECODE: begin
                cnt_d = '0;
                if (op_q == OP_STOP) begin
                    halt_d  = 1'b1;
                    state_d = HALT_WAIT;
                end else if (op_q == OP_RUN || op_q == OP_NONE) begin
                    halt_d  = op_q == OP_RUN ? 1'b0 : halt_q;
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if (!CPU_HALTED) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    err_d   = op_q == OP_WR_REG ? 1'b0 : err_q;
                    state_d = op_q == OP_STEP ? STEP_LOW : op_q == OP_RD_REG ? REG_RD :
                              op_q == OP_WR_REG ? DONE : MEM_WAIT;
                end
            end
            HALT_WAIT, STEP_HIGH: begin
                cnt_d   = cnt_q + 8'd1;
                state_d = CPU_HALTED || timeout ? DONE : state_q;
                err_d   = CPU_HALTED ? 1'b0 : timeout ? 1'b1 : err_q;
            end
            STEP_LOW: begin
                cnt_d   = !CPU_HALTED ? 8'd0 : cnt_q + 8'd1;
                state_d = !CPU_HALTED ? STEP_HIGH : timeout ? DONE : STEP_LOW;
                err_d   = CPU_HALTED && timeout ? 1'b1 : err_q;
            end
            MEM_WAIT: begin
                cnt_d   = cnt_q + 8'd1;
                state_d = MEM_RDY || timeout ? DONE : MEM_WAIT;
                err_d   = MEM_RDY ? 1'b0 : timeout ? 1'b1 : err_q;
            end
            REG_RD: begin
                err_d   = 1'b0;
                state_d = DONE;
            end
            DONE:    state_d = REQ_CLR;
            REQ_CLR: state_d = DEBUG_REQX ? REQ_CLR : IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign halted_ok = state_q == DECODE && CPU_HALTED;
    assign is_mem    = op_q == OP_RD_MEM || op_q == OP_WR_MEM;
    assign is_rd     = op_q == OP_RD_MEM || op_q == OP_RD_REG;
    assign is_reg    = op_q == OP_RD_REG || op_q == OP_WR_REG;
    assign reg_on    = is_reg && (halted_ok || state_q == REG_RD || (state_q == DONE && !err_q));

    assign DEBUG_ACKX      = state_q == DONE;
    assign DEBUG_ADDR_LDX  = halted_ok && is_mem;
    assign DEBUG_ADDR_INCX = state_q == DONE && !err_q && is_mem && arg_q[0];
    assign DEBUG_DOUT_LDX  = state_q == DONE && !err_q && is_rd;
    assign DEBUG_ERR       = err_q;
    assign CPU_HALT_REQ    = halt_q;
    assign CPU_STEP        = halted_ok && op_q == OP_STEP;
    assign DEBUG_MEM_RD    = state_q == MEM_WAIT && op_q == OP_RD_MEM;
    assign DEBUG_MEM_WR    = state_q == MEM_WAIT && op_q == OP_WR_MEM;
    assign DEBUG_REG_WR    = halted_ok && op_q == OP_WR_REG;
    assign DEBUG_REGB_ADDR = reg_on ? arg_q : 4'd0;
    assign DEBUG_DATAX     = !(reg_on && op_q == OP_RD_REG) ? DATAX_DIN :
                             arg_q == 4'hF ? DATAX_PC_A_NEXT :
                             arg_q == 4'hE ? DATAX_CC_DATA : DATAX_REGB_DATA;
endmodule

// File: tb/tb_debug_sequencer.sv
// tb_debug_sequencer: cycle-by-cycle vector table for debug_sequencer (TIMEOUT=8),
// plus a hand-written reset-during-memory-wait sequence.
module tb_debug_sequencer;
    localparam logic [2:0] NONE = 3'd0, STOP = 3'd1, RUN = 3'd2, STEP = 3'd3,
                           RDM = 3'd4, WRM = 3'd5, RDR = 3'd6, WRR = 3'd7;
    localparam logic [15:0] E_ACK = 16'h8000, E_ALD = 16'h4000, E_AINC = 16'h2000,
                            E_DLD = 16'h1000, E_ERR = 16'h0200, H = 16'h0100,
                            E_STEP = 16'h0080, E_MRD = 16'h0040, E_MWR = 16'h0020,
                            E_RWR = 16'h0010;

    typedef struct {
        string       name;
        logic        req;
        logic [2:0]  op;
        logic [3:0]  arg;
        logic        halted;
        logic        mrdy;
        logic [15:0] exp;
    } vec_t;

    logic        CLK = 1'b0, RESET_N = 1'b0, DEBUG_REQX = 1'b0, CPU_HALTED = 1'b0, MEM_RDY = 1'b0;
    logic [2:0]  DEBUG_OPX = '0;
    logic [3:0]  DEBUG_ARGX = '0;
    logic        DEBUG_ACKX, DEBUG_ADDR_LDX, DEBUG_ADDR_INCX, DEBUG_DOUT_LDX, DEBUG_ERR;
    logic        CPU_HALT_REQ, CPU_STEP, DEBUG_MEM_RD, DEBUG_MEM_WR, DEBUG_REG_WR;
    logic [1:0]  DEBUG_DATAX;
    logic [3:0]  DEBUG_REGB_ADDR;
    logic [15:0] outs;
    vec_t        tbl[$];
    int          errors = 0, checks = 0;

    always #5 CLK = ~CLK;

    debug_sequencer #(.TIMEOUT(8)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .DEBUG_REQX(DEBUG_REQX), .DEBUG_OPX(DEBUG_OPX),
        .DEBUG_ARGX(DEBUG_ARGX), .DEBUG_ACKX(DEBUG_ACKX), .DEBUG_ADDR_LDX(DEBUG_ADDR_LDX),
        .DEBUG_ADDR_INCX(DEBUG_ADDR_INCX), .DEBUG_DOUT_LDX(DEBUG_DOUT_LDX),
        .DEBUG_DATAX(DEBUG_DATAX), .DEBUG_ERR(DEBUG_ERR), .CPU_HALT_REQ(CPU_HALT_REQ),
        .CPU_HALTED(CPU_HALTED), .CPU_STEP(CPU_STEP), .DEBUG_MEM_RD(DEBUG_MEM_RD),
        .DEBUG_MEM_WR(DEBUG_MEM_WR), .MEM_RDY(MEM_RDY), .DEBUG_REGB_ADDR(DEBUG_REGB_ADDR),
        .DEBUG_REG_WR(DEBUG_REG_WR)
    );

    assign outs = {DEBUG_ACKX, DEBUG_ADDR_LDX, DEBUG_ADDR_INCX, DEBUG_DOUT_LDX, DEBUG_DATAX,
                   DEBUG_ERR, CPU_HALT_REQ, CPU_STEP, DEBUG_MEM_RD, DEBUG_MEM_WR,
                   DEBUG_REG_WR, DEBUG_REGB_ADDR};

    task automatic add(input string n, input logic rq, input logic [2:0] op, input logic [3:0] arg,
                       input logic h, input logic mr, input logic [15:0] e);
        vec_t v;
        v.name = n; v.req = rq; v.op = op; v.arg = arg; v.halted = h; v.mrdy = mr; v.exp = e;
        tbl.push_back(v);
    endtask

    task automatic add_rdreg(input logic [3:0] a, input logic [1:0] dx);
        logic [15:0] r;
        r = {4'b0, dx, 10'b0} | {12'b0, a};
        add("rdr_idle",   1, RDR, a, 1, 0, H);
        add("rdr_decode", 1, RDR, a, 1, 0, H | r);
        add("rdr_settle", 1, RDR, a, 1, 0, H | r);
        add("rdr_done",   1, RDR, a, 1, 0, E_ACK | E_DLD | H | r);
        add("rdr_clr",    0, RDR, a, 1, 0, H);
    endtask

    // inputs change on the falling edge; outputs are sampled 1 ns later
    task automatic cyc(input logic rq, input logic [2:0] op, input logic [3:0] arg,
                       input logic h, input logic mr);
        @(negedge CLK);
        DEBUG_REQX = rq; DEBUG_OPX = op; DEBUG_ARGX = arg; CPU_HALTED = h; MEM_RDY = mr;
        #1;
    endtask

    task automatic check(input string n, input logic [15:0] e);
        checks++;
        if (outs !== e) begin
            errors++;
            $display("FAIL %s: outputs=%h expected=%h", n, outs, e);
        end
    endtask

    initial begin
        add("stop_idle",   1, STOP, 0, 0, 0, 0);
        add("stop_decode", 1, STOP, 0, 0, 0, 0);
        add("stop_wait0",  1, STOP, 0, 0, 0, H);
        add("stop_wait1",  1, STOP, 0, 0, 0, H);
        add("stop_halted", 1, STOP, 0, 1, 0, H);
        add("stop_done",   1, STOP, 0, 1, 0, E_ACK | H);
        add("stop_clr",    0, STOP, 0, 1, 0, H);
        add("rdm_idle",    1, RDM, 1, 1, 0, H);
        add("rdm_decode",  1, RDM, 1, 1, 0, E_ALD | H);
        add("rdm_wait0",   1, RDM, 1, 1, 0, E_MRD | H);
        add("rdm_wait1",   1, RDM, 1, 0, 0, E_MRD | H);
        add("rdm_wait2",   1, NONE, 0, 0, 0, E_MRD | H);
        add("rdm_wait3",   1, NONE, 0, 0, 1, E_MRD | H);
        add("rdm_done",    1, NONE, 0, 0, 0, E_ACK | E_DLD | E_AINC | H);
        add("rdm_clr",     0, RDM, 1, 1, 0, H);
        add_rdreg(4'hE, 2'd3);
        add_rdreg(4'hF, 2'd2);
        add_rdreg(4'h5, 2'd1);
        add("wrr_idle",    1, WRR, 3, 1, 0, H);
        add("wrr_decode",  1, WRR, 3, 1, 0, E_RWR | H | 16'd3);
        add("wrr_done",    1, WRR, 3, 1, 0, E_ACK | H | 16'd3);
        add("wrr_clr",     0, WRR, 3, 1, 0, H);
        add("wrm_idle",    1, WRM, 1, 1, 0, H);
        add("wrm_decode",  1, WRM, 1, 1, 0, E_ALD | H);
        for (int k = 0; k < 8; k++) add("wrm_wait", 1, WRM, 1, 1, 0, E_MWR | H);
        add("wrm_tmo_done", 1, WRM, 1, 1, 0, E_ACK | E_ERR | H);
        add("wrm_clr",     0, WRM, 1, 1, 0, E_ERR | H);
        add("rdm2_idle",   1, RDM, 0, 1, 0, E_ERR | H);
        add("rdm2_decode", 1, RDM, 0, 1, 0, E_ALD | E_ERR | H);
        for (int k = 0; k < 7; k++) add("rdm2_wait", 1, RDM, 0, 1, 0, E_MRD | E_ERR | H);
        add("rdm2_rdy_tmo", 1, RDM, 0, 1, 1, E_MRD | E_ERR | H);
        add("rdm2_done",   1, RDM, 0, 1, 0, E_ACK | E_DLD | H);
        add("rdm2_clr",    0, RDM, 0, 1, 0, H);
        add("run_idle",    1, RUN, 0, 1, 0, H);
        add("run_decode",  1, RUN, 0, 1, 0, H);
        add("run_done",    1, RUN, 0, 1, 0, E_ACK);
        add("run_clr",     0, RUN, 0, 1, 0, 0);
        add("stepr_idle",  1, STEP, 0, 0, 0, 0);
        add("stepr_decode", 1, STEP, 0, 0, 0, 0);
        add("stepr_done",  1, STEP, 0, 0, 0, E_ACK | E_ERR);
        for (int k = 0; k < 5; k++) add("stepr_held", 1, STEP, 0, 0, 0, E_ERR);
        add("stepr_clr",   0, STEP, 0, 0, 0, E_ERR);
        add("stepr_idle2", 0, STEP, 0, 0, 0, E_ERR);
        add("step_idle",   1, STEP, 0, 1, 0, E_ERR);
        add("step_decode", 1, STEP, 0, 1, 0, E_STEP | E_ERR);
        add("step_low",    1, STEP, 0, 1, 0, E_ERR);
        add("step_low_fall", 1, STEP, 0, 0, 0, E_ERR);
        add("step_high",   1, STEP, 0, 0, 0, E_ERR);
        add("step_high_rise", 1, STEP, 0, 1, 0, E_ERR);
        add("step_done",   1, STEP, 0, 1, 0, E_ACK);
        add("step_clr",    0, STEP, 0, 1, 0, 0);
        add("none_idle",   1, NONE, 0, 0, 0, 0);
        add("none_decode", 1, NONE, 0, 0, 0, 0);
        add("none_done",   1, NONE, 0, 0, 0, E_ACK);
        add("none_clr",    0, NONE, 0, 0, 0, 0);
        add("stopt_idle",  1, STOP, 0, 0, 0, 0);
        add("stopt_decode", 1, STOP, 0, 0, 0, 0);
        for (int k = 0; k < 8; k++) add("stopt_wait", 1, STOP, 0, 0, 0, H);
        add("stopt_done",  1, STOP, 0, 0, 0, E_ACK | E_ERR | H);
        add("stopt_clr",   0, STOP, 0, 0, 0, E_ERR | H);

        RESET_N = 1'b0;
        cyc(0, NONE, 0, 0, 0);
        cyc(0, NONE, 0, 0, 0);
        check("reset", 0);
        RESET_N = 1'b1;
        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].req, tbl[i].op, tbl[i].arg, tbl[i].halted, tbl[i].mrdy);
            check(tbl[i].name, tbl[i].exp);
        end

        cyc(1, RDM, 1, 1, 0);
        cyc(1, RDM, 1, 1, 0);
        cyc(1, RDM, 1, 1, 0);
        check("mid_wait", E_MRD | E_ERR | H);
        RESET_N = 1'b0;
        cyc(1, RDM, 1, 1, 0);
        check("reset_mid_wait", 0);
        RESET_N = 1'b1;
        cyc(1, RDM, 1, 1, 0);
        check("reset_reaccept", E_ALD);
        for (int k = 0; k < 10; k++) begin
            cyc(1, RDM, 1, 1, 1);
            if (DEBUG_ACKX) break;
        end
        check("rerun_done", E_ACK | E_DLD | E_AINC);
        cyc(0, NONE, 0, 1, 0);
        check("rerun_clr", 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/debug_sequencer.md
DEBUG_SEQUENCER -- requirements
Module: debug_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, giving the maximum wait cycles for CPU_HALTED or MEM_RDY before aborting with error.
REQ-002 SHALL have port CLK  in  1  sole clock; all state changes on the rising edge.
REQ-003 SHALL have port RESET_N  in  1  reset; synchronous, active-low.
REQ-004 SHALL have port DEBUG_REQX  in  1  command pending from debugPort; level, held until ACK.
REQ-005 SHALL have port DEBUG_OPX  in  3  command code, encoded per DEBUG_OPX_* constants.
REQ-006 SHALL have port DEBUG_ARGX  in  4  command argument.
REQ-007 SHALL have port DEBUG_ACKX  out  1  one-cycle command-complete pulse.
REQ-008 SHALL have ports DEBUG_ADDR_LDX, DEBUG_ADDR_INCX, DEBUG_DOUT_LDX  out  1 each  one-cycle strobes to debugPort.
REQ-009 SHALL have port DEBUG_DATAX  out  2  debugPort read-back source select, encoded per DEBUG_DATAX_*.
REQ-010 SHALL have port DEBUG_ERR  out  1  last command failed.
REQ-011 SHALL have ports CPU_HALT_REQ  out  1, CPU_HALTED  in  1, CPU_STEP  out  1  for CPU run control.
REQ-012 SHALL have ports DEBUG_MEM_RD, DEBUG_MEM_WR  out  1, MEM_RDY  in  1  for the memory handshake.
REQ-013 SHALL have ports DEBUG_REGB_ADDR  out  4, DEBUG_REG_WR  out  1  for register-bank access.

Function
REQ-014 SHALL implement states IDLE, DECODE, HALT_WAIT, STEP_LOW, STEP_HIGH, MEM_WAIT, REG_RD, DONE, REQ_CLR.
REQ-015 IDLE SHALL move to DECODE on the first edge with DEBUG_REQX=1; OPX/ARGX SHALL be latched on that edge.
REQ-016 NONE or an unused OPX SHALL go to DONE.
REQ-017 STOP SHALL set sticky CPU_HALT_REQ=1 and enter HALT_WAIT; exit to DONE on CPU_HALTED=1.
REQ-018 RUN SHALL clear CPU_HALT_REQ and go to DONE.
REQ-019 STEP with CPU_HALTED=1 SHALL pulse CPU_STEP for 1 cycle, enter STEP_LOW until CPU_HALTED=0, then STEP_HIGH until CPU_HALTED=1, then DONE.
REQ-020 STEP, RD_MEM, WR_MEM, RD_REG or WR_REG issued with CPU_HALTED=0 SHALL go to DONE with DEBUG_ERR=1 and no side effects.
REQ-021 RD_MEM/WR_MEM SHALL pulse DEBUG_ADDR_LDX in DECODE, then in MEM_WAIT hold DEBUG_MEM_RD (or DEBUG_MEM_WR) high until the edge with MEM_RDY=1.
REQ-022 For RD_MEM, DEBUG_DATAX SHALL equal DEBUG_DATAX_DIN throughout MEM_WAIT and DONE.
REQ-023 RD_REG SHALL drive DEBUG_REGB_ADDR=ARGX and DEBUG_DATAX per ARGX: 4'hF -> DEBUG_DATAX_PC_A_NEXT, 4'hE -> DEBUG_DATAX_CC_DATA, else DEBUG_DATAX_REGB_DATA.
REQ-024 RD_REG SHALL spend one REG_RD settle cycle before DONE.
REQ-025 WR_REG SHALL drive DEBUG_REGB_ADDR=ARGX and pulse DEBUG_REG_WR for one cycle, then go to DONE.
REQ-026 DONE SHALL last one cycle and assert DEBUG_ACKX=1.
REQ-027 In DONE, DEBUG_DOUT_LDX SHALL be 1 for successful RD_MEM/RD_REG.
REQ-028 In DONE, DEBUG_ADDR_INCX SHALL be 1 for successful RD_MEM/WR_MEM when latched ARGX[0]=1 (auto-increment).
REQ-029 REQ_CLR SHALL hold until DEBUG_REQX=0, then go to IDLE; no new command SHALL be accepted before then.
REQ-030 An 8-bit wait counter SHALL clear on entry to HALT_WAIT/STEP_LOW/STEP_HIGH/MEM_WAIT and increment each waiting cycle.
REQ-031 When the wait counter reaches TIMEOUT, the sequencer SHALL drop MEM_RD/WR and go to DONE with DEBUG_ERR=1, DEBUG_DOUT_LDX=0, DEBUG_ADDR_INCX=0.
REQ-032 DEBUG_ERR SHALL be updated in DONE and held until the next DONE.
REQ-033 MEM_RDY=1 and timeout on the same edge SHALL count as success.
REQ-034 CPU_HALTED falling during a memory/register op SHALL NOT abort it.

Reset
REQ-035 With RESET_N=0 at an edge, all outputs SHALL be 0 (DEBUG_DATAX=DEBUG_DATAX_DIN), CPU_HALT_REQ=0, counter=0, state=IDLE, from any state including mid-operation.
REQ-036 DEBUG_REQX still high after reset SHALL be treated as a new command.

Verification
REQ-037 STOP, CPU_HALTED rising 3 cycles later -> CPU_HALT_REQ=1 next edge, DEBUG_ACKX pulse 1 cycle after CPU_HALTED=1, DEBUG_ERR=0.
REQ-038 Halted, RD_MEM ARGX=1, MEM_RDY after 4 cycles -> ADDR_LDX 1 cycle, DEBUG_MEM_RD high 4 cycles, DONE with ACKX=DOUT_LDX=ADDR_INCX=1, DATAX=DIN.
REQ-039 Halted, RD_REG ARGX=4'hE -> DATAX=CC_DATA, REGB_ADDR=4'hE, ACKX+DOUT_LDX 2 cycles after DECODE.
REQ-040 Halted, WR_MEM with MEM_RDY tied 0, TIMEOUT=8 -> DEBUG_MEM_WR high 8 cycles, ACKX with DEBUG_ERR=1, no ADDR_INCX.
REQ-041 Running (CPU_HALTED=0), STEP -> no CPU_STEP, ACKX with DEBUG_ERR=1; DEBUG_REQX held high 5 cycles after ACK -> no second ACK.
REQ-042 RESET_N=0 mid-MEM_WAIT -> next edge all outputs 0, CPU_HALT_REQ=0, state IDLE.
